// File: rtl/fc_pkg.sv
// Shared types and defaults for the FC classifier output stage.
// Holds the argmax FSM state encoding and the default score geometry.
package fc_pkg;

  localparam int FC_DATA_W      = 16;
  localparam int FC_NUM_CLASSES = 10;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } argmax_state_t;

endpackage

// File: rtl/argmax_cmp.sv
// Combinational strict greater-than compare of two scores.
// Ports: a, b (DATA_W) in; a_gt_b out. SIGNED_CMP picks two's-complement or unsigned.
module argmax_cmp #(
  parameter int DATA_W     = 16,
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              a_gt_b
);

  if (SIGNED_CMP) begin : g_signed
    assign a_gt_b = $signed(a) > $signed(b);
  end else begin : g_unsigned
    assign a_gt_b = a > b;
  end

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax: takes N scores over valid/ready, returns index and value of the max.
// Ports: clk, reset, start, in_valid/in_data/in_ready, out_valid/out_ready/out_index/out_max, busy.
module argmax_stream
  import fc_pkg::*;
#(
  parameter int DATA_W     = FC_DATA_W,
  parameter int N          = FC_NUM_CLASSES,
  parameter int IDX_W      = $clog2(N),
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [DATA_W-1:0] out_max,
  output logic              busy
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  argmax_state_t     state_q;
  argmax_state_t     state_d;
  logic [IDX_W-1:0]  cnt;
  logic [DATA_W-1:0] max_r;
  logic [IDX_W-1:0]  idx_r;
  logic              accept;
  logic              last;
  logic              gt;

  argmax_cmp #(
    .DATA_W    (DATA_W),
    .SIGNED_CMP(SIGNED_CMP)
  ) u_cmp (
    .a     (in_data),
    .b     (max_r),
    .a_gt_b(gt)
  );

  assign accept = in_valid && (state_q == SCAN);
  assign last   = (cnt == LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = SCAN;
      SCAN: if (accept && last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt     <= '0;
      max_r   <= '0;
      idx_r   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        cnt <= '0;
      end
      if (accept) begin
        cnt <= last ? '0 : cnt + 1'b1;
        // element 0 seeds the running max regardless of stale contents
        if (cnt == '0 || gt) begin
          max_r <= in_data;
          idx_r <= cnt;
        end
      end
    end
  end

  assign in_ready  = (state_q == SCAN);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_index = idx_r;
  assign out_max   = max_r;

endmodule

// File: tb/tb_argmax_stream.sv
// Scoreboard bench for argmax_stream across four parameter sets.
// Drivers push reference results; monitors pop and compare on each output.
module tb_argmax_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef bit [31:0] frame_t[$];
  typedef struct {
    longint idx;
    longint val;
  } res_t;

  int spec_vals[10] = '{3, -2, 7, 7, 1, 0, -5, 6, 2, 4};

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference: interpret each score as an integer, keep first strict maximum
  function automatic res_t ref_argmax(frame_t f, int dw, int sc);
    res_t   r;
    longint m;
    longint best;
    longint v;
    m    = (longint'(1) << dw) - 1;
    best = 0;
    r.idx = 0;
    r.val = 0;
    for (int i = 0; i < f.size(); i++) begin
      v = longint'(f[i]) & m;
      if (sc != 0 && v >= (longint'(1) << (dw - 1)))
        v = v - (longint'(1) << dw);
      if (i == 0 || v > best) begin
        best  = v;
        r.idx = i;
        r.val = longint'(f[i]) & m;
      end
    end
    return r;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int NN = (g == 2) ? 2 : (g == 3) ? 16 : 10;
    localparam int DW = (g == 2) ? 8 : (g == 3) ? 32 : 16;
    localparam int SC = (g == 1) ? 0 : 1;
    localparam int IW = $clog2(NN);

    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_index;
    logic [DW-1:0] out_max;
    logic          busy;
    bit            fin = 1'b0;
    res_t          q[$];

    argmax_stream #(
      .DATA_W    (DW),
      .N         (NN),
      .IDX_W     (IW),
      .SIGNED_CMP(SC[0])
    ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_index(out_index),
      .out_max  (out_max),
      .busy     (busy)
    );

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    task automatic c(string nm, longint act, longint exp);
      chk($sformatf("cfg%0d_%s", g, nm), act, exp);
    endtask

    task automatic wait_idle();
      int t = 0;
      while (busy && t < 100) begin
        step();
        t++;
      end
      c("idle_timeout", busy, 0);
    endtask

    task automatic run_frame(frame_t f, bit gaps, int abort_at);
      in_valid = 1'b1;
      in_data  = '1;
      step();
      c("idle_in_ready", in_ready, 0);
      in_valid = 1'b0;
      start    = 1'b1;
      step();
      start = 1'b0;
      c("scan_in_ready", in_ready, 1);
      c("scan_busy", busy, 1);
      if (abort_at < 0) q.push_back(ref_argmax(f, DW, SC));
      for (int i = 0; i < NN; i++) begin
        if (gaps) begin
          repeat ($urandom_range(0, 3)) begin
            in_valid = 1'b0;
            start    = 1'($urandom_range(0, 1));
            step();
          end
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = DW'(f[i]);
        step();
        if (i == abort_at) begin
          in_valid = 1'b0;
          reset    = 1'b1;
          step();
          reset = 1'b0;
          c("abort_out_valid", out_valid, 0);
          c("abort_in_ready", in_ready, 0);
          c("abort_busy", busy, 0);
          c("abort_index", out_index, 0);
          c("abort_max", out_max, 0);
          return;
        end
      end
      in_valid = 1'b0;
      c("valid_after_last", out_valid, 1);
      c("done_in_ready", in_ready, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_idle();
    endtask

    initial begin : driver
      frame_t f;
      bit [31:0] msb;
      bit [31:0] big;
      int t;
      msb = 32'(longint'(1) << (DW - 1));
      big = 32'(longint'(1) << (DW - 2));
      step();
      step();
      c("rst_out_valid", out_valid, 0);
      c("rst_in_ready", in_ready, 0);
      c("rst_busy", busy, 0);
      c("rst_index", out_index, 0);
      c("rst_max", out_max, 0);
      reset = 1'b0;
      step();

      if (NN == 10) begin
        f = {};
        for (int i = 0; i < 10; i++) f.push_back(32'(spec_vals[i]));
        run_frame(f, 1'b0, -1);
      end
      f = {};
      for (int i = 0; i < NN; i++) f.push_back(msb);
      run_frame(f, 1'b0, -1);
      f = {};
      f.push_back(msb);
      f.push_back(msb - 1);
      for (int i = 2; i < NN; i++) f.push_back(32'd1);
      run_frame(f, 1'b1, -1);
      f = {};
      for (int i = 0; i < NN - 1; i++) f.push_back(32'(i));
      f.push_back(big);
      run_frame(f, 1'b1, -1);
      f = {};
      f.push_back(big);
      for (int i = 1; i < NN; i++) f.push_back((i % 2 == 1) ? big : 32'(i));
      run_frame(f, 1'b1, -1);
      if (g == 0) begin
        f = '{32'd1, 32'd2, 32'd3, 32'd50, 32'd4, 32'd60, 32'd0, 32'd0, 32'd0, 32'd0};
        run_frame(f, 1'b0, 4);
        f = {};
        for (int i = 0; i < 9; i++) f.push_back(32'd0);
        f.push_back(32'd9);
        run_frame(f, 1'b0, -1);
      end
      repeat (20) begin
        f = {};
        for (int i = 0; i < NN; i++)
          f.push_back(($urandom_range(0, 3) != 0) ? $urandom() : 32'($urandom_range(0, 3)));
        run_frame(f, 1'b1, -1);
      end
      t = 0;
      while ((q.size() != 0 || busy) && t < 200) begin
        step();
        t++;
      end
      c("drain", q.size(), 0);
      fin = 1'b1;
    end

    initial begin : monitor
      res_t          e;
      logic [IW-1:0] hi;
      logic [DW-1:0] hm;
      forever begin
        step();
        if (!reset && out_valid) begin
          hi = out_index;
          hm = out_max;
          if (q.size() == 0) begin
            c("unexpected_out", 1, 0);
          end else begin
            e = q.pop_front();
            c("out_index", out_index, e.idx);
            c("out_max", out_max, e.val);
          end
          if ($urandom_range(0, 1) == 1) begin
            repeat (5) begin
              step();
              c("hold_valid", out_valid, 1);
              c("hold_index", out_index, hi);
              c("hold_max", out_max, hm);
            end
          end
          out_ready = 1'b1;
          step();
          out_ready = 1'b0;
          c("valid_drop", out_valid, 0);
          c("idle_keep_index", out_index, hi);
        end
      end
    end
  end

  initial begin : top
    int t = 0;
    while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin) && t < 90000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 90000) begin
      n_chk++;
      n_fail++;
      $display("FAIL global_timeout: got %0d cycles required < 90000", t);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
